// File: rtl/prot_pkg.sv
// Shared constants for the protection-comparator qualification filters:
// FSM state encoding, 50 MHz default qualification windows and channel map.
package prot_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_QUAL = 2'd1;
    localparam logic [1:0] ST_TRIP = 2'd2;
    localparam logic [1:0] ST_REL  = 2'd3;

    // 50 samples at 50 MHz = 1 us qualification window
    localparam int DEF_ASSERT_CNT  = 50;
    localparam int DEF_RELEASE_CNT = 50;

    localparam int CH_BUS_OVP  = 0;
    localparam int CH_IP_OCP   = 1;
    localparam int CH_INV_OCP1 = 2;
    localparam int CH_OP_OVP1  = 3;
    localparam int CH_INV_OCP2 = 4;
    localparam int CH_OP_OVP2  = 5;

    // Width of a channel index; a single-channel build still gets one bit
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/prot_filter_ch.sv
// One protection channel: input synchroniser, assert/release qualification
// FSM with a shared up-counter, and the registered active-low fault output.
//
//  state | meaning
//  ------+-------------------------------------------------------------
//  IDLE  | healthy, no fault sample seen
//  QUAL  | fault present, counting consecutive fault samples
//  TRIP  | fault qualified, output held low
//  REL   | auto-release only: counting consecutive healthy samples
module prot_filter_ch
    import prot_pkg::*;
#(
    parameter int CNT_W       = 8,
    parameter int ASSERT_CNT  = DEF_ASSERT_CNT,
    parameter int RELEASE_CNT = DEF_RELEASE_CNT,
    parameter bit LATCHED     = 1'b1,
    parameter int SYNC_STG    = 2
) (
    input  logic CLK_50M,
    input  logic Rst_n,
    input  logic flt_in_n,
    input  logic ch_en,
    input  logic fault_clr,
    output logic flt_out_n,
    output logic enter_trip
);

    localparam logic [CNT_W-1:0] ASSERT_LAST  = CNT_W'(ASSERT_CNT - 1);
    localparam logic [CNT_W-1:0] RELEASE_LAST = CNT_W'(RELEASE_CNT - 1);

    logic [SYNC_STG-1:0] sync;
    logic                f;
    logic [1:0]          state;
    logic [1:0]          state_nxt;
    logic [CNT_W-1:0]    cnt;
    logic [CNT_W-1:0]    cnt_nxt;

    // Resync the asynchronous comparator output; reset value is "healthy"
    always_ff @(posedge CLK_50M) begin
        if (!Rst_n) begin
            sync <= '1;
        end else begin
            sync <= {sync[SYNC_STG-2:0], flt_in_n};
        end
    end

    assign f = ~sync[SYNC_STG-1] & ch_en;

    // Next-state and counter rules; the counter only ever climbs to the
    // compare value before a transition, so it cannot wrap
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            ST_IDLE: begin
                cnt_nxt = '0;
                if (f) begin
                    if (ASSERT_CNT == 1) begin
                        state_nxt = ST_TRIP;
                    end else begin
                        state_nxt = ST_QUAL;
                        cnt_nxt   = CNT_W'(1);
                    end
                end
            end
            ST_QUAL: begin
                if (!f) begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                end else if (cnt == ASSERT_LAST) begin
                    state_nxt = ST_TRIP;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            ST_TRIP: begin
                cnt_nxt = '0;
                if (LATCHED) begin
                    // A clear is only honoured once the fault has gone away
                    if (fault_clr && !f) begin
                        state_nxt = ST_IDLE;
                    end
                end else if (!f) begin
                    if (RELEASE_CNT == 1) begin
                        state_nxt = ST_IDLE;
                    end else begin
                        state_nxt = ST_REL;
                        cnt_nxt   = CNT_W'(1);
                    end
                end
            end
            ST_REL: begin
                if (f) begin
                    state_nxt = ST_TRIP;
                    cnt_nxt   = '0;
                end else if (cnt == RELEASE_LAST) begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    assign enter_trip = (state_nxt == ST_TRIP) && (state != ST_TRIP);

    // State and counter registers
    always_ff @(posedge CLK_50M) begin
        if (!Rst_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Output stays low through REL so a release is only seen once qualified
    always_ff @(posedge CLK_50M) begin
        if (!Rst_n) begin
            flt_out_n <= 1'b1;
        end else begin
            flt_out_n <= ~((state == ST_TRIP) || (state == ST_REL));
        end
    end

endmodule

// File: rtl/prot_filter_multi.sv
// N-channel protection qualification filter. Per-channel filtering lives in
// prot_filter_ch; this level only combines the channels into the PWM-kill
// trip and records which channel tripped first.
module prot_filter_multi
    import prot_pkg::*;
#(
    parameter int              N_CH        = 6,
    parameter int              CNT_W       = 8,
    parameter int              ASSERT_CNT  = DEF_ASSERT_CNT,
    parameter int              RELEASE_CNT = DEF_RELEASE_CNT,
    parameter logic [N_CH-1:0] LATCH_MASK  = {N_CH{1'b1}},
    parameter int              SYNC_STG    = 2
) (
    input  logic                     CLK_50M,
    input  logic                     Rst_n,
    input  logic [N_CH-1:0]          Flt_In_n,
    input  logic [N_CH-1:0]          Ch_En,
    input  logic                     Fault_Clr,
    output logic [N_CH-1:0]          Flt_Out_n,
    output logic                     Trip_n,
    output logic [idx_w(N_CH)-1:0]   First_Idx,
    output logic                     First_Vld
);

    localparam int IDX_W = idx_w(N_CH);

    logic [N_CH-1:0]  enter;
    logic [IDX_W-1:0] first_enc;

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        prot_filter_ch #(
            .CNT_W      (CNT_W),
            .ASSERT_CNT (ASSERT_CNT),
            .RELEASE_CNT(RELEASE_CNT),
            .LATCHED    (LATCH_MASK[g]),
            .SYNC_STG   (SYNC_STG)
        ) u_ch (
            .CLK_50M   (CLK_50M),
            .Rst_n     (Rst_n),
            .flt_in_n  (Flt_In_n[g]),
            .ch_en     (Ch_En[g]),
            .fault_clr (Fault_Clr),
            .flt_out_n (Flt_Out_n[g]),
            .enter_trip(enter[g])
        );
    end

    // Lowest-numbered channel entering TRIP this cycle wins
    always_comb begin
        first_enc = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (enter[i]) begin
                first_enc = IDX_W'(i);
            end
        end
    end

    // PWM kill: one register stage after the per-channel outputs
    always_ff @(posedge CLK_50M) begin
        if (!Rst_n) begin
            Trip_n <= 1'b1;
        end else begin
            Trip_n <= &Flt_Out_n;
        end
    end

    // First-fault record; a new trip coinciding with a clear is captured
    always_ff @(posedge CLK_50M) begin
        if (!Rst_n) begin
            First_Idx <= '0;
            First_Vld <= 1'b0;
        end else if ((|enter) && (!First_Vld || Fault_Clr)) begin
            First_Idx <= first_enc;
            First_Vld <= 1'b1;
        end else if (Fault_Clr) begin
            First_Vld <= 1'b0;
        end
    end

endmodule

// File: tb/tb_prot_filter_multi.sv
// Bench for prot_filter_multi: a vector table, hand-timed sequences for the
// latency/latch/priority/reset cases, and randomized stimulus compared every
// cycle against a run-length model of the qualification rules.
module tb_prot_filter_multi;

    localparam int         N_CH  = 6;
    localparam int         A_CNT = 50;
    localparam int         R_CNT = 50;
    localparam int         SYNC  = 2;
    localparam logic [5:0] LMASK = 6'b101010;   // ch0/2/4 auto-release, ch1/3/5 latched

    logic       CLK_50M = 1'b0;
    logic       Rst_n = 1'b0;
    logic [5:0] Flt_In_n = '1;
    logic [5:0] Ch_En = '1;
    logic       Fault_Clr = 1'b0;
    logic [5:0] Flt_Out_n;
    logic       Trip_n;
    logic [2:0] First_Idx;
    logic       First_Vld;

    int checks = 0;
    int errors = 0;
    bit mchk = 1'b0;

    prot_filter_multi #(
        .N_CH(N_CH), .CNT_W(8), .ASSERT_CNT(A_CNT), .RELEASE_CNT(R_CNT),
        .LATCH_MASK(LMASK), .SYNC_STG(SYNC)
    ) dut (
        .CLK_50M(CLK_50M), .Rst_n(Rst_n), .Flt_In_n(Flt_In_n), .Ch_En(Ch_En),
        .Fault_Clr(Fault_Clr), .Flt_Out_n(Flt_Out_n), .Trip_n(Trip_n),
        .First_Idx(First_Idx), .First_Vld(First_Vld)
    );

    always #10 CLK_50M = ~CLK_50M;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(negedge CLK_50M);
    endtask

    task automatic pulse_clr();
        Fault_Clr = 1'b1;
        tick();
        Fault_Clr = 1'b0;
    endtask

    // ---------------- reference model ----------------
    // Each channel: tripped flag plus lengths of the current run of fault /
    // healthy samples; the input reaches the filter SYNC samples late.
    logic [5:0] hist [SYNC];
    bit         trp [6];
    int         lo [6];
    int         hi [6];
    logic [5:0] m_out = '1;
    logic       m_trip = 1'b1;
    logic       m_vld = 1'b0;
    logic [2:0] m_idx = '0;
    logic [5:0] ms, mf, ment, tvec;

    always @(posedge CLK_50M) begin
        if (!Rst_n) begin
            for (int k = 0; k < SYNC; k++) hist[k] = '1;
            for (int i = 0; i < 6; i++) begin trp[i] = 0; lo[i] = 0; hi[i] = 0; end
            m_out = '1; m_trip = 1'b1; m_vld = 1'b0; m_idx = '0;
        end else begin
            ms = hist[SYNC-1];
            mf = ~ms & Ch_En;
            ment = '0;
            for (int i = 0; i < 6; i++) tvec[i] = trp[i];
            m_trip = &m_out;
            m_out  = ~tvec;
            for (int i = 0; i < 6; i++) begin
                if (!trp[i]) begin
                    lo[i] = mf[i] ? lo[i] + 1 : 0;
                    if (lo[i] == A_CNT) begin trp[i] = 1; hi[i] = 0; ment[i] = 1'b1; end
                end else if (!LMASK[i]) begin
                    if (mf[i]) begin
                        if (hi[i] > 0) ment[i] = 1'b1;
                        hi[i] = 0;
                    end else begin
                        hi[i]++;
                        if (hi[i] == R_CNT) begin trp[i] = 0; lo[i] = 0; hi[i] = 0; end
                    end
                end else if (Fault_Clr && !mf[i]) begin
                    trp[i] = 0; lo[i] = 0;
                end
            end
            if (ment != 0 && (!m_vld || Fault_Clr)) begin
                m_vld = 1'b1;
                for (int i = 5; i >= 0; i--) if (ment[i]) m_idx = 3'(i);
            end else if (Fault_Clr) begin
                m_vld = 1'b0;
            end
            for (int k = SYNC - 1; k > 0; k--) hist[k] = hist[k-1];
            hist[0] = Flt_In_n;
        end
    end

    always @(negedge CLK_50M) begin
        if (mchk) begin
            chk("model_flt_out", Flt_Out_n, m_out);
            chk("model_trip", Trip_n, m_trip);
            chk("model_first_vld", First_Vld, m_vld);
            if (m_vld) chk("model_first_idx", First_Idx, m_idx);
        end
    end

    // ---------------- vector table ----------------
    typedef struct {
        logic [5:0] fin;
        logic [5:0] en;
        logic       clr;
        int         cyc;
        logic [5:0] eflt;
        logic       etrip;
        logic       evld;
        logic [2:0] eidx;
    } vec_t;

    vec_t tbl [14];

    initial begin
        int n;
        int bad;

        tbl[0]  = '{6'h3F, 6'h3F, 1'b0,   5, 6'h3F, 1'b1, 1'b0, 3'd0};
        tbl[1]  = '{6'h3E, 6'h3F, 1'b0,  52, 6'h3F, 1'b1, 1'b1, 3'd0};
        tbl[2]  = '{6'h3E, 6'h3F, 1'b0,   1, 6'h3E, 1'b1, 1'b1, 3'd0};
        tbl[3]  = '{6'h3E, 6'h3F, 1'b0,   1, 6'h3E, 1'b0, 1'b1, 3'd0};
        tbl[4]  = '{6'h3F, 6'h3F, 1'b0,  52, 6'h3E, 1'b0, 1'b1, 3'd0};
        tbl[5]  = '{6'h3F, 6'h3F, 1'b0,   1, 6'h3F, 1'b0, 1'b1, 3'd0};
        tbl[6]  = '{6'h3F, 6'h3F, 1'b0,   1, 6'h3F, 1'b1, 1'b1, 3'd0};
        tbl[7]  = '{6'h3F, 6'h3F, 1'b1,   1, 6'h3F, 1'b1, 1'b0, 3'd0};
        tbl[8]  = '{6'h37, 6'h37, 1'b0,  80, 6'h3F, 1'b1, 1'b0, 3'd0};
        tbl[9]  = '{6'h37, 6'h3F, 1'b0,  53, 6'h37, 1'b0, 1'b1, 3'd3};
        tbl[10] = '{6'h3F, 6'h3F, 1'b0, 100, 6'h37, 1'b0, 1'b1, 3'd3};
        tbl[11] = '{6'h3F, 6'h3F, 1'b1,   1, 6'h37, 1'b0, 1'b0, 3'd3};
        tbl[12] = '{6'h3F, 6'h3F, 1'b0,   1, 6'h3F, 1'b0, 1'b0, 3'd3};
        tbl[13] = '{6'h3F, 6'h3F, 1'b0,   1, 6'h3F, 1'b1, 1'b0, 3'd3};

        Rst_n = 1'b0;
        tick(3);
        chk("rst_flt_out", Flt_Out_n, 6'h3F);
        chk("rst_trip", Trip_n, 1'b1);
        chk("rst_first_vld", First_Vld, 1'b0);
        chk("rst_first_idx", First_Idx, 3'd0);
        mchk = 1'b1;
        Rst_n = 1'b1;

        for (int v = 0; v < 14; v++) begin
            Flt_In_n  = tbl[v].fin;
            Ch_En     = tbl[v].en;
            Fault_Clr = tbl[v].clr;
            tick(tbl[v].cyc);
            Fault_Clr = 1'b0;
            chk($sformatf("vec%0d_flt_out", v), Flt_Out_n, tbl[v].eflt);
            chk($sformatf("vec%0d_trip", v), Trip_n, tbl[v].etrip);
            chk($sformatf("vec%0d_first_vld", v), First_Vld, tbl[v].evld);
            chk($sformatf("vec%0d_first_idx", v), First_Idx, tbl[v].eidx);
        end

        // 1: assert latency of ch0
        Flt_In_n[0] = 1'b0;
        n = 0;
        while (Flt_Out_n[0] !== 1'b0 && n < 200) begin tick(); n++; end
        chk("t1_out_latency", n, 53);
        while (Trip_n !== 1'b0 && n < 200) begin tick(); n++; end
        chk("t1_trip_latency", n, 54);
        chk("t1_first_idx", First_Idx, 3'd0);
        chk("t1_first_vld", First_Vld, 1'b1);
        tick(6);
        Flt_In_n[0] = 1'b1;
        tick(60);

        // 2: glitch restarts qualification on ch1
        bad = 0;
        Flt_In_n[1] = 1'b0;
        for (int c = 0; c < 49; c++) begin tick(); if (Flt_Out_n[1] !== 1'b1) bad++; end
        Flt_In_n[1] = 1'b1;
        tick(); if (Flt_Out_n[1] !== 1'b1) bad++;
        Flt_In_n[1] = 1'b0;
        for (int c = 0; c < 49; c++) begin tick(); if (Flt_Out_n[1] !== 1'b1) bad++; end
        Flt_In_n[1] = 1'b1;
        for (int c = 0; c < 60; c++) begin tick(); if (Flt_Out_n[1] !== 1'b1) bad++; end
        chk("t2_glitch_no_trip", bad, 0);

        // 3: auto-release ch2, then a low pulse during release
        Flt_In_n[2] = 1'b0;
        tick(60);
        chk("t3_tripped", Flt_Out_n[2], 1'b0);
        Flt_In_n[2] = 1'b1;
        n = 0;
        while (Flt_Out_n[2] !== 1'b1 && n < 200) begin tick(); n++; end
        chk("t3_release_latency", n, 53);
        Flt_In_n[2] = 1'b0;
        tick(60);
        Flt_In_n[2] = 1'b1;
        tick(20);
        Flt_In_n[2] = 1'b0;
        bad = 0;
        for (int c = 0; c < 10; c++) begin tick(); if (Flt_Out_n[2] !== 1'b0) bad++; end
        chk("t3_rel_glitch_held", bad, 0);
        Flt_In_n[2] = 1'b1;
        n = 0;
        while (Flt_Out_n[2] !== 1'b1 && n < 200) begin tick(); n++; end
        chk("t3_rerelease_latency", n, 53);

        // 4: latched ch3
        pulse_clr();
        Flt_In_n[3] = 1'b0;
        tick(60);
        chk("t4_tripped", Flt_Out_n[3], 1'b0);
        chk("t4_first_idx", First_Idx, 3'd3);
        Flt_In_n[3] = 1'b1;
        tick(200);
        chk("t4_latched_hold", Flt_Out_n[3], 1'b0);
        Flt_In_n[3] = 1'b0;
        tick(5);
        pulse_clr();
        tick(3);
        chk("t4_clr_while_low", Flt_Out_n[3], 1'b0);
        Flt_In_n[3] = 1'b1;
        tick(5);
        Flt_In_n[0] = 1'b0;          // ch0 starts qualifying so First_Vld is re-armed below
        tick(); Flt_In_n[0] = 1'b1;
        pulse_clr();
        chk("t4_clr_first_vld", First_Vld, 1'b0);
        chk("t4_clr_edge_out", Flt_Out_n[3], 1'b0);
        tick();
        chk("t4_clr_released", Flt_Out_n[3], 1'b1);

        // 5: simultaneous trip priority and disabled channel
        tick(5);
        pulse_clr();
        Flt_In_n[5:4] = 2'b00;
        tick(60);
        chk("t5_first_idx", First_Idx, 3'd4);
        chk("t5_first_vld", First_Vld, 1'b1);
        chk("t5_both_tripped", Flt_Out_n[5:4], 2'b00);
        Flt_In_n[5:4] = 2'b11;
        tick(5);
        pulse_clr();
        tick(60);
        chk("t5_both_released", Flt_Out_n[5:4], 2'b11);
        Ch_En[5] = 1'b0;
        Flt_In_n[5] = 1'b0;
        bad = 0;
        for (int c = 0; c < 100; c++) begin tick(); if (Flt_Out_n[5] !== 1'b1) bad++; end
        chk("t5_disabled_no_trip", bad, 0);
        Flt_In_n[5] = 1'b1;
        tick(5);
        Ch_En[5] = 1'b1;

        // 6: reset while ch0 tripped
        Flt_In_n[0] = 1'b0;
        tick(60);
        chk("t6_tripped", Flt_Out_n[0], 1'b0);
        Rst_n = 1'b0;
        tick();
        chk("t6_rst_flt_out", Flt_Out_n, 6'h3F);
        chk("t6_rst_trip", Trip_n, 1'b1);
        chk("t6_rst_first_vld", First_Vld, 1'b0);
        chk("t6_rst_first_idx", First_Idx, 3'd0);
        Rst_n = 1'b1;
        n = 0;
        while (Flt_Out_n[0] !== 1'b0 && n < 200) begin tick(); n++; end
        chk("t6_requalify_latency", n, 53);
        Flt_In_n[0] = 1'b1;
        tick(60);

        // randomized stimulus against the model
        for (int c = 0; c < 4000; c++) begin
            for (int i = 0; i < 6; i++) begin
                if ($urandom_range(0, 59) == 0) Flt_In_n[i] = ~Flt_In_n[i];
                if ($urandom_range(0, 299) == 0) Ch_En[i] = ~Ch_En[i];
            end
            Fault_Clr = ($urandom_range(0, 39) == 0);
            Rst_n = ($urandom_range(0, 1999) != 0);
            tick();
        end
        Rst_n = 1'b1;
        Fault_Clr = 1'b0;
        tick(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
